// File: rtl/spi_crc3_check_pkg.sv
// Shared definitions for the serial CRC checker and its matching generator.
package spi_crc3_check_pkg;

  localparam int unsigned WCODE_DEF = 4;
  localparam int unsigned WPOLY_DEF = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/crc_serial_step.sv
// One-bit CRC remainder update; the polynomial MSB is implied and not carried.
module crc_serial_step #(
  parameter int unsigned WPOLY = 4
) (
  input  logic [WPOLY-2:0] rem_i,
  input  logic             bit_i,
  input  logic [WPOLY-2:0] poly_i,
  output logic [WPOLY-2:0] rem_o
);

  logic fb;

  always_comb begin
    fb    = rem_i[WPOLY-2];
    rem_o = {rem_i[WPOLY-3:0], bit_i} ^ (fb ? poly_i : '0);
  end

endmodule

// File: rtl/spi_crc3_check.sv
// Serial CRC checker: shifts in a codeword MSB first and reports data and syndrome.
module spi_crc3_check
  import spi_crc3_check_pkg::*;
#(
  parameter int unsigned WCODE = WCODE_DEF,
  parameter int unsigned WPOLY = WPOLY_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WPOLY-1:0] i_poly,
  input  logic             i_frame_start,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WCODE-1:0] o_data,
  output logic [WPOLY-2:0] o_syndrome,
  output logic             o_crc_ok
);

  localparam int unsigned CW = $clog2(WCODE + WPOLY);
  localparam logic [CW-1:0] LastCnt  = CW'(WCODE + WPOLY - 2);
  localparam logic [CW-1:0] DataBits = CW'(WCODE);

  state_e           state_q, state_d;
  logic [WPOLY-2:0] poly_q, poly_d;
  logic [WPOLY-2:0] rem_q, rem_d;
  logic [WCODE-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WCODE-1:0] out_data_q, out_data_d;
  logic [WPOLY-2:0] out_syn_q, out_syn_d;
  logic             out_ok_q, out_ok_d;
  logic [WPOLY-2:0] rem_step;

  crc_serial_step #(
    .WPOLY(WPOLY)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (i_bit),
    .poly_i(poly_q),
    .rem_o (rem_step)
  );

  always_comb begin
    state_d    = state_q;
    poly_d     = poly_q;
    rem_d      = rem_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_syn_d  = out_syn_q;
    out_ok_d   = out_ok_q;

    // A frame start wins in every state; any bit offered in that cycle is dropped.
    if (i_frame_start) begin
      state_d = StShift;
      poly_d  = i_poly[WPOLY-2:0];
      rem_d   = '0;
      data_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: state_d = StIdle;
        StShift: begin
          if (i_bit_valid) begin
            rem_d = rem_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q < DataBits) begin
              data_d = {data_q[WCODE-2:0], i_bit};
            end
            if (cnt_q == LastCnt) begin
              state_d    = StDone;
              out_data_d = data_d;
              out_syn_d  = rem_step;
              out_ok_d   = (rem_step == '0);
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      poly_q     <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_syn_q  <= '0;
      out_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      poly_q     <= poly_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_syn_q  <= out_syn_d;
      out_ok_q   <= out_ok_d;
    end
  end

  assign o_busy     = (state_q != StIdle);
  assign o_valid    = (state_q == StDone);
  assign o_data     = out_data_q;
  assign o_syndrome = out_syn_q;
  assign o_crc_ok   = out_ok_q;

endmodule

// File: tb/tb_spi_crc3_check.sv
// Bench for spi_crc3_check: vector table, corner-case sequences and random frames.
module tb_spi_crc3_check;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [3:0] i_poly;
  logic       i_frame_start;
  logic       i_bit_valid;
  logic       i_bit;
  logic       o_busy;
  logic       o_valid;
  logic [3:0] o_data;
  logic [2:0] o_syndrome;
  logic       o_crc_ok;

  spi_crc3_check #(
    .WCODE(4),
    .WPOLY(4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_poly       (i_poly),
    .i_frame_start(i_frame_start),
    .i_bit_valid  (i_bit_valid),
    .i_bit        (i_bit),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_syndrome   (o_syndrome),
    .o_crc_ok     (o_crc_ok)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       ok;
  } exp_t;

  typedef struct {
    logic [3:0] data;
    logic [2:0] crc;
    logic [3:0] poly;
    logic [2:0] syn;
    logic       ok;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vcount   = 0;

  always @(posedge i_clk) begin
    if (o_valid) vcount <= vcount + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference long division of a 7-bit codeword by {1, plo}.
  function automatic logic [2:0] divrem(input logic [6:0] cw, input logic [2:0] plo);
    logic [6:0] r;
    logic [3:0] g;
    r = cw;
    g = {1'b1, plo};
    for (int i = 6; i >= 3; i--) begin
      if (r[i]) r[i-:4] = r[i-:4] ^ g;
    end
    return r[2:0];
  endfunction

  task automatic open_frame(input logic [3:0] p);
    i_poly        = p;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    i_poly        = 4'($urandom);
  endtask

  // Shifts all 7 bits; returns after the edge that accepts the last one.
  task automatic send_bits(input logic [6:0] cw, input int maxgap, input int v0);
    for (int i = 6; i >= 0; i--) begin
      repeat ($urandom_range(maxgap)) tick();
      i_bit       = cw[i];
      i_bit_valid = 1'b1;
      tick();
      i_bit_valid = 1'b0;
      if (i != 0) chk("no_early_valid", vcount, v0);
    end
  endtask

  task automatic check_done(input int v0);
    exp_t e;
    chk("valid_after_last", o_valid, 1);
    chk("busy_in_done", o_busy, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("data", o_data, e.data);
      chk("syndrome", o_syndrome, e.syn);
      chk("crc_ok", o_crc_ok, e.ok);
    end
  endtask

  task automatic run_frame(input logic [3:0] d, input logic [2:0] c, input logic [3:0] p,
                           input logic [2:0] es, input logic eok, input int maxgap);
    int v0;
    sb.push_back('{data: d, syn: es, ok: eok});
    v0 = vcount;
    open_frame(p);
    chk("busy_in_shift", o_busy, 1);
    send_bits({d, c}, maxgap, v0);
    check_done(v0);
    tick();
    chk("valid_one_cycle", o_valid, 0);
    chk("single_valid", vcount, v0 + 1);
    chk("idle_after_done", o_busy, 0);
    chk("hold_data", o_data, d);
    chk("hold_ok", o_crc_ok, eok);
  endtask

  initial begin
    int         v0;
    logic [3:0] d;
    logic [3:0] p;
    logic [2:0] c;
    logic [6:0] cw;
    logic [2:0] es;

    vecs[0] = '{data: 4'b1101, crc: 3'b001, poly: 4'b1011, syn: 3'b000, ok: 1'b1};
    vecs[1] = '{data: 4'b1101, crc: 3'b011, poly: 4'b1011, syn: 3'b010, ok: 1'b0};
    vecs[2] = '{data: 4'b0000, crc: 3'b000, poly: 4'b1011, syn: 3'b000, ok: 1'b1};
    vecs[3] = '{data: 4'b1010, crc: 3'b011, poly: 4'b1011, syn: 3'b000, ok: 1'b1};
    vecs[4] = '{data: 4'b1010, crc: 3'b000, poly: 4'b1011, syn: 3'b011, ok: 1'b0};
    vecs[5] = '{data: 4'b1001, crc: 3'b011, poly: 4'b1101, syn: 3'b000, ok: 1'b1};

    i_rst = 1'b1;
    i_poly = 4'b0;
    i_frame_start = 1'b0;
    i_bit_valid = 1'b0;
    i_bit = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_syn", o_syndrome, 0);
    chk("rst_ok", o_crc_ok, 0);

    foreach (vecs[k]) begin
      run_frame(vecs[k].data, vecs[k].crc, vecs[k].poly, vecs[k].syn, vecs[k].ok, 3);
    end

    // Bits offered while idle must not start or disturb anything.
    v0 = vcount;
    for (int i = 0; i < 8; i++) begin
      i_bit_valid = 1'b1;
      i_bit = i[0];
      tick();
    end
    i_bit_valid = 1'b0;
    chk("idle_bits_busy", o_busy, 0);
    chk("idle_bits_valid", vcount, v0);
    chk("idle_bits_hold", o_data, 4'b1001);

    // Restart after 3 bits; the bit offered alongside the restart is dropped.
    v0 = vcount;
    sb.push_back('{data: 4'b1101, syn: 3'b000, ok: 1'b1});
    open_frame(4'b1011);
    for (int i = 0; i < 3; i++) begin
      i_bit_valid = 1'b1;
      i_bit = 1'b1;
      tick();
    end
    i_poly = 4'b1011;
    i_frame_start = 1'b1;
    i_bit = 1'b1;
    tick();
    i_frame_start = 1'b0;
    i_bit_valid = 1'b0;
    chk("restart_busy", o_busy, 1);
    send_bits(7'b1101001, 1, v0);
    check_done(v0);
    tick();
    chk("restart_one_valid", vcount, v0 + 1);

    // Frame start during DONE: result still reported, next frame starts at once.
    v0 = vcount;
    sb.push_back('{data: 4'b1101, syn: 3'b010, ok: 1'b0});
    open_frame(4'b1011);
    send_bits(7'b1101011, 0, v0);
    check_done(v0);
    i_poly = 4'b1011;
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    chk("done_restart_busy", o_busy, 1);
    chk("done_restart_valid", o_valid, 0);
    sb.push_back('{data: 4'b1010, syn: 3'b000, ok: 1'b1});
    send_bits(7'b1010011, 2, v0 + 1);
    check_done(v0 + 1);
    tick();
    chk("done_restart_count", vcount, v0 + 2);

    // Reset mid-frame discards it and clears the held results.
    run_frame(4'b1101, 3'b001, 4'b1011, 3'b000, 1'b1, 0);
    v0 = vcount;
    open_frame(4'b1011);
    for (int i = 0; i < 4; i++) begin
      i_bit_valid = 1'b1;
      i_bit = i[0];
      tick();
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_bit_valid = 1'b0;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_syn", o_syndrome, 0);
    chk("midrst_ok", o_crc_ok, 0);
    repeat (6) tick();
    chk("midrst_no_valid", vcount, v0);

    // Random frames: generator CRC, optional single-bit corruption.
    for (int n = 0; n < 40; n++) begin
      d = 4'($urandom);
      p = 4'($urandom);
      c = divrem({d, 3'b000}, p[2:0]);
      cw = {d, c};
      if ($urandom_range(1) == 1) cw[$urandom_range(6)] ^= 1'b1;
      es = divrem(cw, p[2:0]);
      run_frame(cw[6:3], cw[2:0], p, es, (es == 3'b000), 2);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
